// File: rtl/ctrl_pkg.sv
// Shared constants for the pipeline control unit: instruction encodings,
// ALU op codes and the layout of the control word carried down the pipe.
package ctrl_pkg;

   // Major opcodes (instruction[6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_R      = 7'b0110011;

   // funct3 selections (instruction[14:12])
   localparam logic [2:0] F3_BYTE  = 3'b000;
   localparam logic [2:0] F3_WORD  = 3'b010;
   localparam logic [2:0] F3_BEQ   = 3'b000;
   localparam logic [2:0] F3_JALR  = 3'b000;
   localparam logic [2:0] F3_ADDI  = 3'b000;
   localparam logic [2:0] F3_ARITH = 3'b000;

   // funct7 selections (instruction[31:25])
   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;
   localparam logic [6:0] F7_MUL = 7'b0000001;

   // ALU operation classes
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_FN  = 2'b10;

   // Control word field positions
   localparam int CW_REGWRITE = 0;
   localparam int CW_MEMWRITE = 1;
   localparam int CW_LOAD     = 2;
   localparam int CW_BRANCH   = 3;
   localparam int CW_JUMP     = 4;
   localparam int CW_BYTE     = 5;
   localparam int CW_ALUSRC   = 6;
   localparam int CW_MEMTOREG = 7;
   localparam int CW_ALUOP_LO = 8;
   localparam int CW_ALUOP_HI = 9;
   localparam int CW_ILLEGAL  = 10;
   localparam int CW_VALID    = 11;
   localparam int CW_W        = 12;

   // An empty pipeline slot: no side effects, not counted at retirement
   localparam logic [CW_W-1:0] BUBBLE = {CW_W{1'b0}};

   // A fetched instruction that matched no enabled encoding
   localparam logic [CW_W-1:0] CW_ILL_WORD = {1'b1, 1'b1, {(CW_W-2){1'b0}}};

   // Assemble a valid, legal control word from individual controls
   function automatic logic [CW_W-1:0] cw_legal(
      input logic       regwrite,
      input logic       memwrite,
      input logic       load,
      input logic       branch,
      input logic       jump,
      input logic       byte_sel,
      input logic       alusrc,
      input logic       memtoreg,
      input logic [1:0] aluop
   );
      return {1'b1, 1'b0, aluop, memtoreg, alusrc, byte_sel,
              jump, branch, load, memwrite, regwrite};
   endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline control register: hold when en_i is low, load zero when bub_i
// is high (bubble wins over both hold and load).
module ctrl_stage_reg #(
   parameter int W = 12
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic         bub_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_q;

   // Stage register with async clear, bubble insertion and hold
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= {W{1'b0}};
      end else if (bub_i) begin
         data_q <= {W{1'b0}};
      end else if (en_i) begin
         data_q <= d_i;
      end else begin
         data_q <= data_q;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Main decoder plus D/E/M/W control pipeline with stall, flush and freeze
// handling, illegal-instruction flagging and a retired-instruction counter.
module pipe_ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int CNTW    = 32,
   parameter int MUL_EN  = 1,
   parameter int BYTE_EN = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ihit,
   input  logic            dhit,
   input  logic            stallD,
   input  logic            flushE,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   output logic            MemWriteD,
   output logic            LoadD,
   output logic            BranchD,
   output logic            JumpD,
   output logic            ByteD,
   output logic            ALUSrcE,
   output logic [1:0]      aluopE,
   output logic            MemWriteM,
   output logic            LoadM,
   output logic            RegWriteW,
   output logic            ByteW,
   output logic            MemtoRegW,
   output logic            IllegalW,
   output logic [CNTW-1:0] retired
);

   logic [CW_W-1:0] dec_d;
   logic [CW_W-1:0] regd_q;
   logic [CW_W-1:0] rege_q;
   logic [CW_W-1:0] regm_q;
   logic [CW_W-1:0] regw_q;
   logic [CNTW-1:0] retired_q;

   logic d_en_s;
   logic d_bub_s;
   logic e_en_s;
   logic e_bub_s;
   logic m_en_s;
   logic w_bub_s;

   // Decode the fetched instruction into a control word
   always_comb begin
      dec_d = BUBBLE;
      if (ihit) begin
         case (opcode)
            OP_LOAD: begin
               if (funct3 == F3_WORD) begin
                  dec_d = cw_legal(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ALU_ADD);
               end else if ((funct3 == F3_BYTE) && (BYTE_EN != 0)) begin
                  dec_d = cw_legal(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, ALU_ADD);
               end else begin
                  dec_d = CW_ILL_WORD;
               end
            end
            OP_STORE: begin
               if (funct3 == F3_WORD) begin
                  dec_d = cw_legal(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD);
               end else if ((funct3 == F3_BYTE) && (BYTE_EN != 0)) begin
                  dec_d = cw_legal(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD);
               end else begin
                  dec_d = CW_ILL_WORD;
               end
            end
            OP_BRANCH: begin
               if (funct3 == F3_BEQ) begin
                  dec_d = cw_legal(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB);
               end else begin
                  dec_d = CW_ILL_WORD;
               end
            end
            OP_JALR: begin
               if (funct3 == F3_JALR) begin
                  dec_d = cw_legal(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD);
               end else begin
                  dec_d = CW_ILL_WORD;
               end
            end
            OP_IMM: begin
               if (funct3 == F3_ADDI) begin
                  dec_d = cw_legal(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD);
               end else begin
                  dec_d = CW_ILL_WORD;
               end
            end
            OP_R: begin
               if ((funct3 == F3_ARITH) &&
                   ((funct7 == F7_ADD) || (funct7 == F7_SUB) ||
                    ((funct7 == F7_MUL) && (MUL_EN != 0)))) begin
                  dec_d = cw_legal(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_FN);
               end else begin
                  dec_d = CW_ILL_WORD;
               end
            end
            default: begin
               dec_d = CW_ILL_WORD;
            end
         endcase
      end else begin
         dec_d = BUBBLE;
      end
   end

   // Per-stage hold/bubble controls: a cache miss freezes everything, a
   // taken branch kills D and E, a load-use hazard holds D and bubbles E
   always_comb begin
      d_en_s  = 1'b1;
      d_bub_s = 1'b0;
      e_en_s  = 1'b1;
      e_bub_s = 1'b0;
      m_en_s  = 1'b1;
      w_bub_s = 1'b0;
      if (!dhit) begin
         d_en_s  = 1'b0;
         e_en_s  = 1'b0;
         m_en_s  = 1'b0;
         w_bub_s = 1'b1;
      end else if (flushE) begin
         d_bub_s = 1'b1;
         e_bub_s = 1'b1;
      end else if (stallD) begin
         d_en_s  = 1'b0;
         e_bub_s = 1'b1;
      end else begin
         d_en_s  = 1'b1;
      end
   end

   ctrl_stage_reg #(.W(CW_W)) u_regd (
      .clk_i (clk), .rst_ni (reset), .en_i (d_en_s), .bub_i (d_bub_s),
      .d_i   (dec_d), .q_o (regd_q)
   );

   ctrl_stage_reg #(.W(CW_W)) u_rege (
      .clk_i (clk), .rst_ni (reset), .en_i (e_en_s), .bub_i (e_bub_s),
      .d_i   (regd_q), .q_o (rege_q)
   );

   ctrl_stage_reg #(.W(CW_W)) u_regm (
      .clk_i (clk), .rst_ni (reset), .en_i (m_en_s), .bub_i (1'b0),
      .d_i   (rege_q), .q_o (regm_q)
   );

   ctrl_stage_reg #(.W(CW_W)) u_regw (
      .clk_i (clk), .rst_ni (reset), .en_i (1'b1), .bub_i (w_bub_s),
      .d_i   (regm_q), .q_o (regw_q)
   );

   // Count legal instructions leaving W; a frozen W holds a bubble, so no
   // instruction is counted twice
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retired_q <= {CNTW{1'b0}};
      end else if (regw_q[CW_VALID] && !regw_q[CW_ILLEGAL]) begin
         retired_q <= retired_q + CNTW'(1);
      end else begin
         retired_q <= retired_q;
      end
   end

   assign MemWriteD = regd_q[CW_MEMWRITE];
   assign LoadD     = regd_q[CW_LOAD];
   assign BranchD   = regd_q[CW_BRANCH];
   assign JumpD     = regd_q[CW_JUMP];
   assign ByteD     = regd_q[CW_BYTE];
   assign ALUSrcE   = rege_q[CW_ALUSRC];
   assign aluopE    = rege_q[CW_ALUOP_HI:CW_ALUOP_LO];
   assign MemWriteM = regm_q[CW_MEMWRITE];
   assign LoadM     = regm_q[CW_LOAD];
   assign RegWriteW = regw_q[CW_REGWRITE];
   assign ByteW     = regw_q[CW_BYTE];
   assign MemtoRegW = regw_q[CW_MEMTOREG];
   assign IllegalW  = regw_q[CW_ILLEGAL] & regw_q[CW_VALID];
   assign retired   = retired_q;

   // Fields carried along for downstream stages but not exported here
   logic unused_fields;
   assign unused_fields = ^{regd_q[CW_REGWRITE], regd_q[CW_ALUSRC], regd_q[CW_MEMTOREG],
                            regd_q[CW_ALUOP_HI:CW_ALUOP_LO], regd_q[CW_ILLEGAL], regd_q[CW_VALID],
                            rege_q[CW_REGWRITE], rege_q[CW_MEMWRITE], rege_q[CW_LOAD],
                            rege_q[CW_BRANCH], rege_q[CW_JUMP], rege_q[CW_BYTE],
                            rege_q[CW_MEMTOREG], rege_q[CW_ILLEGAL], rege_q[CW_VALID],
                            regm_q[CW_REGWRITE], regm_q[CW_BRANCH], regm_q[CW_JUMP],
                            regm_q[CW_BYTE], regm_q[CW_ALUSRC], regm_q[CW_MEMTOREG],
                            regm_q[CW_ALUOP_HI:CW_ALUOP_LO], regm_q[CW_ILLEGAL], regm_q[CW_VALID],
                            regw_q[CW_MEMWRITE], regw_q[CW_LOAD], regw_q[CW_BRANCH],
                            regw_q[CW_JUMP], regw_q[CW_ALUSRC], regw_q[CW_ALUOP_HI:CW_ALUOP_LO]};

endmodule
